// File: rtl/post_tu.sv
// ============================================================================
// Module      : post_tu
// Description : Winograd F(2,3) output transform. Consumes a 4x4 product tile
//               row by row and emits the 2x2 result Y = A^T M A.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module post_tu #(
    parameter int IW = 32,
    parameter int OW = IW + 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [IW-1:0] in_m0,
    input  logic signed [IW-1:0] in_m1,
    input  logic signed [IW-1:0] in_m2,
    input  logic signed [IW-1:0] in_m3,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_y00,
    output logic signed [OW-1:0] out_y01,
    output logic signed [OW-1:0] out_y10,
    output logic signed [OW-1:0] out_y11,
    output logic                 tile_done
);

    localparam int       c_EXT  = OW - IW - 2;
    localparam logic [1:0] c_ROW0 = 2'd0;
    localparam logic [1:0] c_ROW1 = 2'd1;
    localparam logic [1:0] c_ROW2 = 2'd2;
    localparam logic [1:0] c_ROW3 = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                w_xfer;
    logic                w_load;
    logic signed [IW+1:0] w_t0;
    logic signed [IW+1:0] w_t1;
    logic signed [OW-1:0] w_e0;
    logic signed [OW-1:0] w_e1;
    logic signed [OW-1:0] r_acc0_0;
    logic signed [OW-1:0] r_acc0_1;
    logic signed [OW-1:0] r_acc1_0;
    logic signed [OW-1:0] r_acc1_1;
    logic signed [OW-1:0] r_y00;
    logic signed [OW-1:0] r_y01;
    logic signed [OW-1:0] r_y10;
    logic signed [OW-1:0] r_y11;
    logic                r_out_valid;
    logic                r_tile_done;

    // Only the closing row can collide with a stalled result, so only it waits.
    assign in_ready = (r_state != c_ROW3) || !r_out_valid || out_ready;
    assign w_xfer   = in_valid && in_ready;
    assign w_load   = w_xfer && (r_state == c_ROW3);

    // Row transform (M * A), exact at IW+2 bits
    assign w_t0 = {{2{in_m0[IW-1]}}, in_m0} + {{2{in_m1[IW-1]}}, in_m1}
                + {{2{in_m2[IW-1]}}, in_m2};
    assign w_t1 = {{2{in_m1[IW-1]}}, in_m1} - {{2{in_m2[IW-1]}}, in_m2}
                - {{2{in_m3[IW-1]}}, in_m3};
    assign w_e0 = {{c_EXT{w_t0[IW+1]}}, w_t0};
    assign w_e1 = {{c_EXT{w_t1[IW+1]}}, w_t1};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ROW0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_xfer) begin
            case (r_state)
                c_ROW0:  w_state_nxt = c_ROW1;
                c_ROW1:  w_state_nxt = c_ROW2;
                c_ROW2:  w_state_nxt = c_ROW3;
                default: w_state_nxt = c_ROW0;
            endcase
        end
    end

    // Column transform (A^T * T) folded into per-row accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc0_0    <= '0;
            r_acc0_1    <= '0;
            r_acc1_0    <= '0;
            r_acc1_1    <= '0;
            r_y00       <= '0;
            r_y01       <= '0;
            r_y10       <= '0;
            r_y11       <= '0;
            r_out_valid <= 1'b0;
            r_tile_done <= 1'b0;
        end else begin
            if (w_xfer) begin
                case (r_state)
                    c_ROW0: begin
                        r_acc0_0 <= w_e0;
                        r_acc0_1 <= w_e1;
                        r_acc1_0 <= '0;
                        r_acc1_1 <= '0;
                    end
                    c_ROW1: begin
                        r_acc0_0 <= r_acc0_0 + w_e0;
                        r_acc0_1 <= r_acc0_1 + w_e1;
                        r_acc1_0 <= w_e0;
                        r_acc1_1 <= w_e1;
                    end
                    c_ROW2: begin
                        r_acc0_0 <= r_acc0_0 + w_e0;
                        r_acc0_1 <= r_acc0_1 + w_e1;
                        r_acc1_0 <= r_acc1_0 - w_e0;
                        r_acc1_1 <= r_acc1_1 - w_e1;
                    end
                    default: begin
                        r_acc1_0 <= r_acc1_0 - w_e0;
                        r_acc1_1 <= r_acc1_1 - w_e1;
                    end
                endcase
            end

            if (w_load) begin
                r_y00       <= r_acc0_0;
                r_y01       <= r_acc0_1;
                r_y10       <= r_acc1_0 - w_e0;
                r_y11       <= r_acc1_1 - w_e1;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            r_tile_done <= w_load;
        end
    end

    assign out_valid = r_out_valid;
    assign out_y00   = r_y00;
    assign out_y01   = r_y01;
    assign out_y10   = r_y10;
    assign out_y11   = r_y11;
    assign tile_done = r_tile_done;

endmodule

`default_nettype wire

// File: tb/tb_post_tu.sv
// ============================================================================
// Module      : tb_post_tu
// Description : Self-checking bench for post_tu against a matrix-product model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_post_tu;

    localparam int IW = 32;
    localparam int OW = IW + 4;

    typedef logic [15:0][IW-1:0] tile_t;
    typedef logic [3:0][OW-1:0]  res_t;
    typedef struct {
        tile_t m;
        res_t  y;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [IW-1:0] in_m0, in_m1, in_m2, in_m3;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_y00, out_y01, out_y10, out_y11;
    logic                 tile_done;

    int   n_chk      = 0;
    int   n_pass     = 0;
    int   td_cnt     = 0;
    int   tiles_sent = 0;
    bit   rnd_ready  = 1'b0;
    res_t exp_q[$];
    res_t mon_e;
    res_t prev_y;
    bit   prev_v     = 1'b0;
    bit   prev_r     = 1'b0;
    vec_t tv[4];
    tile_t seq_t;
    tile_t rt;

    post_tu #(.IW(IW), .OW(OW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_m0     (in_m0),
        .in_m1     (in_m1),
        .in_m2     (in_m2),
        .in_m3     (in_m3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y00   (out_y00),
        .out_y01   (out_y01),
        .out_y10   (out_y10),
        .out_y11   (out_y11),
        .tile_done (tile_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Y = A^T * M * A with A = [[1,0],[1,1],[1,-1],[0,-1]]
    function automatic res_t model(input tile_t m);
        int     a[4][2];
        longint s;
        res_t   r;
        a = '{'{1, 0}, '{1, 1}, '{1, -1}, '{0, -1}};
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = 0;
                for (int rr = 0; rr < 4; rr++)
                    for (int cc = 0; cc < 4; cc++)
                        s += longint'(a[rr][i]) * longint'($signed(m[rr*4+cc])) * longint'(a[cc][j]);
                r[i*2+j] = s[OW-1:0];
            end
        end
        return r;
    endfunction

    task automatic send_row(input logic [IW-1:0] a, b, c, d);
        bit ok = 1'b0;
        in_m0 = a; in_m1 = b; in_m2 = c; in_m3 = d;
        in_valid = 1'b1;
        for (int k = 0; k < 500 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("row_accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_tile(input tile_t m, input int maxgap, input bit chk_gap);
        int g;
        for (int r = 0; r < 4; r++) begin
            send_row(m[r*4], m[r*4+1], m[r*4+2], m[r*4+3]);
            if (r < 3 && maxgap > 0) begin
                g = $urandom_range(1, maxgap);
                repeat (g) begin
                    @(negedge clk);
                    if (chk_gap) chk("gap_no_output", out_valid, 0);
                    @(posedge clk);
                    #1;
                end
            end
        end
        exp_q.push_back(model(m));
        tiles_sent++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(posedge clk) begin
        if (rnd_ready) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Output monitor: ordering, stall stability, tile_done alignment
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r && out_valid) begin
                chk("stall_hold_y00", out_y00, $signed(prev_y[0]));
                chk("stall_hold_y11", out_y11, $signed(prev_y[3]));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", exp_q.size(), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_y00", out_y00, $signed(mon_e[0]));
                    chk("out_y01", out_y01, $signed(mon_e[1]));
                    chk("out_y10", out_y10, $signed(mon_e[2]));
                    chk("out_y11", out_y11, $signed(mon_e[3]));
                end
            end
            if (tile_done) begin
                td_cnt++;
                chk("tile_done_with_valid", out_valid, 1);
            end
            prev_v = out_valid;
            prev_r = out_ready;
            prev_y = {out_y11, out_y10, out_y01, out_y00};
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_m0 = '0; in_m1 = '0; in_m2 = '0; in_m3 = '0;

        for (int k = 0; k < 16; k++) seq_t[k] = IW'(k + 1);
        tv[0].m = seq_t;
        tv[0].y[0] = 36'sd54;  tv[0].y[1] = -36'sd27;
        tv[0].y[2] = -36'sd54; tv[0].y[3] = 36'sd21;
        tv[1].m = {16{32'h7fff_ffff}};
        tv[1].y[0] = 36'sd19327352823; tv[1].y[1] = -36'sd6442450941;
        tv[1].y[2] = -36'sd6442450941; tv[1].y[3] = 36'sd2147483647;
        tv[2].m = {16{32'h8000_0000}};
        tv[2].y[0] = -36'sd19327352832; tv[2].y[1] = 36'sd6442450944;
        tv[2].y[2] = 36'sd6442450944;   tv[2].y[3] = -36'sd2147483648;
        tv[3].m = '0; tv[3].m[0] = 32'd1; tv[3].m[15] = 32'd1;
        tv[3].y[0] = 36'sd1; tv[3].y[1] = 36'sd0;
        tv[3].y[2] = 36'sd0; tv[3].y[3] = 36'sd1;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_tile_done", tile_done, 0);
        chk("reset_y00", out_y00, 0);
        chk("reset_y11", out_y11, 0);
        @(posedge clk); #1;

        // Directed vectors: result one cycle after row 3
        for (int i = 0; i < 4; i++) begin
            send_tile(tv[i].m, 0, 1'b0);
            @(negedge clk);
            chk("tbl_valid", out_valid, 1);
            chk("tbl_tile_done", tile_done, 1);
            chk("tbl_y00", out_y00, $signed(tv[i].y[0]));
            chk("tbl_y01", out_y01, $signed(tv[i].y[1]));
            chk("tbl_y10", out_y10, $signed(tv[i].y[2]));
            chk("tbl_y11", out_y11, $signed(tv[i].y[3]));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("tbl_clear_valid", out_valid, 0);
        chk("tbl_clear_done", tile_done, 0);
        @(posedge clk); #1;

        // Back-pressure: rows 0..2 of next tile flow, row 3 waits
        out_ready = 1'b0;
        send_tile(seq_t, 0, 1'b0);
        for (int r = 0; r < 3; r++) send_row('0, '0, '0, '0);
        in_m0 = '0; in_m1 = '0; in_m2 = '0; in_m3 = '0; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_hold_y00", out_y00, 54);
            chk("bp_valid", out_valid, 1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send_row('0, '0, '0, '0);
        exp_q.push_back(model('0));
        tiles_sent++;
        idle(3);

        // Reset mid-tile discards the partial rows
        send_row(seq_t[0], seq_t[1], seq_t[2], seq_t[3]);
        send_row(seq_t[4], seq_t[5], seq_t[6], seq_t[7]);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        send_tile(seq_t, 0, 1'b0);
        idle(3);
        chk("rst_mid_one_output", exp_q.size(), 0);

        // Reset with a stalled result drops it
        out_ready = 1'b0;
        send_tile(seq_t, 0, 1'b0);
        idle(2);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_stall_drop", out_valid, 0);
            chk("rst_stall_in_ready", in_ready, 1);
            @(posedge clk); #1;
        end

        // Gapped input
        send_tile(seq_t, 3, 1'b1);
        @(negedge clk);
        chk("gap_valid", out_valid, 1);
        chk("gap_y10", out_y10, -54);
        @(posedge clk); #1;
        idle(2);

        // Random tiles with random downstream readiness
        rnd_ready = 1'b1;
        for (int t = 0; t < 100; t++) begin
            for (int k = 0; k < 16; k++) begin
                case ($urandom_range(0, 3))
                    0:       rt[k] = 32'h7fff_ffff;
                    1:       rt[k] = 32'h8000_0000;
                    default: rt[k] = $urandom();
                endcase
            end
            send_tile(rt, 0, 1'b0);
        end
        rnd_ready = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
        idle(2);
        chk("drain_empty", exp_q.size(), 0);
        chk("tile_done_count", td_cnt, tiles_sent);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
